// File: rtl/pirdsp_pkg.sv
// Shared constants for the PIRDSP split-output multiplier and its consumers:
// mode encoding, partial-result lane geometry and a mode normalising helper.
package pirdsp_pkg;

    typedef enum logic [1:0] {
        MODE_27X18   = 2'b00,
        MODE_SUM_9X9 = 2'b01
    } pirdsp_mode_e;

    localparam int RESULT_W    = 45;
    localparam int CARRY_W     = 4;
    localparam int LANE1_LSB   = 27;
    localparam int LANE0_DROP  = 9;
    localparam int LANE1_SEG_W = 18;
    localparam int LANE_SUM_W  = 20;

    // Unused codes behave as the 27x18 product.
    function automatic pirdsp_mode_e normalize_mode(input logic [1:0] code);
        return (code == 2'b01) ? MODE_SUM_9X9 : MODE_27X18;
    endfunction

endpackage

// File: rtl/pirdsp_final_adder.sv
// Combinational carry-propagate add of the redundant partial-result pair,
// producing either one wide product or two independent 20-bit lane sums.
module pirdsp_final_adder
    import pirdsp_pkg::*;
#(
    parameter int ACC_W  = 48,
    parameter int LANE_W = ACC_W / 2
) (
    input  pirdsp_mode_e          mode,
    input  logic                  a_sign,
    input  logic                  b_sign,
    input  logic [RESULT_W-1:0]   result_0,
    input  logic [RESULT_W-1:0]   result_1,
    input  logic [CARRY_W-1:0]    carry,
    output logic [ACC_W-1:0]      sum
);

    logic                    ext_sign;
    logic [RESULT_W-1:0]     wide_sum;
    logic [LANE1_LSB+1:0]    lane0_raw;
    logic [LANE_SUM_W-1:0]   lane_sum [2];
    logic [LANE_W-1:0]       lane_ext [2];

    assign ext_sign = a_sign || b_sign;
    assign wide_sum = result_0 + result_1;

    // Lane 0 keeps its 9 guard bits out of the result; lane 1 simply wraps at 20 bits.
    assign lane0_raw   = {carry[1:0], result_0[LANE1_LSB-1:0]} + {2'b00, result_1[LANE1_LSB-1:0]};
    assign lane_sum[0] = lane0_raw[LANE0_DROP +: LANE_SUM_W];
    assign lane_sum[1] = {carry[3:2], result_0[RESULT_W-1:LANE1_LSB]}
                       + {2'b00, result_1[RESULT_W-1:LANE1_LSB]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane_ext
            assign lane_ext[gi] = ext_sign ? LANE_W'($signed(lane_sum[gi]))
                                           : LANE_W'(lane_sum[gi]);
        end
    endgenerate

    always_comb begin
        sum = '0;
        if (mode == MODE_SUM_9X9) begin
            sum = ACC_W'({lane_ext[1], lane_ext[0]});
        end else if (ext_sign) begin
            sum = ACC_W'($signed(wide_sum));
        end else begin
            sum = ACC_W'(wide_sum);
        end
    end

endmodule

// File: rtl/pirdsp_partial_result_accumulator.sv
// Two-stage valid/ready pipeline: stage 1 registers the final-added beat,
// stage 2 loads or accumulates it into the running value driven on out_acc.
module pirdsp_partial_result_accumulator
    import pirdsp_pkg::*;
#(
    parameter int ACC_W  = 48,
    parameter int LANE_W = ACC_W / 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic                  a_sign,
    input  logic                  b_sign,
    input  logic                  first,
    input  logic [RESULT_W-1:0]   result_0,
    input  logic [RESULT_W-1:0]   result_1,
    input  logic [CARRY_W-1:0]    result_SIDM_carry,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_acc,
    output logic [1:0]            out_mode,
    output logic                  err_mode
);

    pirdsp_mode_e        mode_norm;
    logic [ACC_W-1:0]    sum_comb;

    logic                s1_valid_reg;
    logic                s1_valid_next;
    logic [ACC_W-1:0]    s1_sum_reg;
    pirdsp_mode_e        s1_mode_reg;
    logic                s1_first_reg;

    logic                s2_valid_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    pirdsp_mode_e        acc_mode_reg;
    logic                err_mode_reg;
    logic                err_mode_next;

    logic                advance;
    logic                accept;
    logic                move;
    logic                mode_change;
    logic                load;
    logic [ACC_W-1:0]    lane_acc_sum;

    assign mode_norm = normalize_mode(mode);

    pirdsp_final_adder #(
        .ACC_W  (ACC_W),
        .LANE_W (LANE_W)
    ) u_final_adder (
        .mode     (mode_norm),
        .a_sign   (a_sign),
        .b_sign   (b_sign),
        .result_0 (result_0),
        .result_1 (result_1),
        .carry    (result_SIDM_carry),
        .sum      (sum_comb)
    );

    // Handshake: stage 2 frees up whenever its value is consumed or absent.
    assign advance       = !s2_valid_reg || out_ready;
    assign in_ready      = !s1_valid_reg || advance;
    assign accept        = in_valid && in_ready;
    assign move          = s1_valid_reg && advance;
    assign s1_valid_next = accept || (s1_valid_reg && !advance);

    assign mode_change   = (s1_mode_reg != acc_mode_reg);
    assign load          = s1_first_reg || mode_change;
    assign err_mode_next = err_mode_reg || (mode_change && !s1_first_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane_acc
            assign lane_acc_sum[gi*LANE_W +: LANE_W] =
                acc_reg[gi*LANE_W +: LANE_W] + s1_sum_reg[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg + s1_sum_reg;
        if (load) begin
            acc_next = s1_sum_reg;
        end else if (s1_mode_reg == MODE_SUM_9X9) begin
            acc_next = lane_acc_sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            s1_mode_reg  <= MODE_27X18;
            s1_first_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            acc_reg      <= '0;
            acc_mode_reg <= MODE_27X18;
            err_mode_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            if (accept) begin
                s1_sum_reg   <= sum_comb;
                s1_mode_reg  <= mode_norm;
                s1_first_reg <= first;
            end
            if (advance) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (move) begin
                acc_reg      <= acc_next;
                acc_mode_reg <= s1_mode_reg;
                err_mode_reg <= err_mode_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_acc   = acc_reg;
    assign out_mode  = acc_mode_reg;
    assign err_mode  = err_mode_reg;

endmodule

// File: tb/tb_pirdsp_partial_result_accumulator.sv
// Self-checking bench: directed scenarios plus randomized streaming against
// a transaction-level model of the final add and running accumulation.
module tb_pirdsp_partial_result_accumulator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'b00;
    logic        a_sign = 1'b0;
    logic        b_sign = 1'b0;
    logic        first = 1'b0;
    logic [44:0] result_0 = '0;
    logic [44:0] result_1 = '0;
    logic [3:0]  result_SIDM_carry = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_acc;
    logic [1:0]  out_mode;
    logic        err_mode;

    int checks = 0;
    int fails  = 0;

    logic [47:0] m_acc;
    logic [1:0]  m_mode;
    bit          m_err;
    logic [47:0] exp_acc [$];
    logic [1:0]  exp_mode [$];
    bit          exp_err [$];

    pirdsp_partial_result_accumulator dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mode              (mode),
        .a_sign            (a_sign),
        .b_sign            (b_sign),
        .first             (first),
        .result_0          (result_0),
        .result_1          (result_1),
        .result_SIDM_carry (result_SIDM_carry),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_acc           (out_acc),
        .out_mode          (out_mode),
        .err_mode          (err_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference final add computed from the lane rules with plain integer arithmetic.
    function automatic logic [47:0] ref_sum(input logic [1:0] md, input bit sg,
                                            input logic [44:0] r0, input logic [44:0] r1,
                                            input logic [3:0] c);
        logic [63:0] t;
        logic [63:0] l0;
        logic [63:0] l1;
        if (md == 2'b01) begin
            t  = (64'(c[1:0]) << 27) + (64'(r0) & 64'h7FF_FFFF) + (64'(r1) & 64'h7FF_FFFF);
            l0 = (t >> 9) & 64'hF_FFFF;
            t  = (64'(c[3:2]) << 18) + (64'(r0) >> 27) + (64'(r1) >> 27);
            l1 = t & 64'hF_FFFF;
            if (sg && l0[19]) l0 = l0 | 64'hF0_0000;
            if (sg && l1[19]) l1 = l1 | 64'hF0_0000;
            return {l1[23:0], l0[23:0]};
        end
        t = (64'(r0) + 64'(r1)) & ((64'd1 << 45) - 64'd1);
        if (sg && t[44]) t = t | ~((64'd1 << 45) - 64'd1);
        return t[47:0];
    endfunction

    task automatic model_reset();
        m_acc  = '0;
        m_mode = 2'b00;
        m_err  = 1'b0;
        exp_acc.delete();
        exp_mode.delete();
        exp_err.delete();
    endtask

    // Applies the beat currently on the DUT inputs to the model.
    task automatic model_accept();
        logic [1:0]  md;
        logic [47:0] s;
        bit          ld;
        md = (mode == 2'b01) ? 2'b01 : 2'b00;
        s  = ref_sum(md, a_sign || b_sign, result_0, result_1, result_SIDM_carry);
        ld = first || (md != m_mode);
        if (!first && md != m_mode) m_err = 1'b1;
        if (ld)
            m_acc = s;
        else if (md == 2'b01)
            m_acc = {m_acc[47:24] + s[47:24], m_acc[23:0] + s[23:0]};
        else
            m_acc = m_acc + s;
        m_mode = md;
        exp_acc.push_back(m_acc);
        exp_mode.push_back(m_mode);
        exp_err.push_back(m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Presents one beat and holds it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [1:0] md, input bit as, input bit bs, input bit fst,
                             input logic [44:0] r0, input logic [44:0] r1, input logic [3:0] c);
        bit ok;
        ok = 1'b0;
        mode = md; a_sign = as; b_sign = bs; first = fst;
        result_0 = r0; result_1 = r1; result_SIDM_carry = c;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_acc !== 48'd0 || out_mode !== 2'b00 || err_mode !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: acc=%h mode=%0d err=%0b required 0/0/0", out_acc, out_mode, err_mode);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        $display("txn reset: acc=%h mode=%0d err=%0b", out_acc, out_mode, err_mode);
    endtask

    task automatic test_load_add();
        do_reset();
        send_beat(2'b00, 1'b0, 1'b0, 1'b1, 45'd100, 45'd23, 4'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: out_valid=%0b required 0 one edge after accept", out_valid);
        end
        send_beat(2'b00, 1'b1, 1'b0, 1'b0, 45'(-5), 45'd0, 4'h0);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 48'd123) begin
            fails++;
            $display("FAIL load_first: valid=%0b acc=%0d required 1/123", out_valid, out_acc);
        end
        $display("txn load: acc=%0d", out_acc);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 48'd118) begin
            fails++;
            $display("FAIL add_signed: valid=%0b acc=%0d required 1/118", out_valid, out_acc);
        end
        $display("txn add: acc=%0d", out_acc);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_lanes();
        do_reset();
        send_beat(2'b01, 1'b0, 1'b0, 1'b1, {18'h0, 27'h7FF_FE00}, {18'h0, 27'h000_0400}, 4'b0000);
        send_beat(2'b01, 1'b0, 1'b0, 1'b0, {18'h3FFFF, 27'h0}, {18'h00001, 27'h0}, 4'b1100);
        checks++;
        if (out_acc !== {24'h000000, 24'h040001} || out_mode !== 2'b01) begin
            fails++;
            $display("FAIL lane_carry: acc=%h mode=%0d required 000000040001/1", out_acc, out_mode);
        end
        $display("txn lane_carry: acc=%h", out_acc);
        @(posedge clk);
        #1;
        checks++;
        if (out_acc !== {24'h000000, 24'h040001} || err_mode !== 1'b0) begin
            fails++;
            $display("FAIL lane_isolation: acc=%h err=%0b required 000000040001/0", out_acc, err_mode);
        end
        $display("txn lane_isolation: acc=%h", out_acc);
    endtask

    task automatic test_backpressure();
        int  idx;
        int  got;
        bit  acc_ev;
        bit  drn_ev;
        logic [47:0] front;
        do_reset();
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            if (idx < 4) begin
                mode = 2'b00; a_sign = 1'b0; b_sign = 1'b0; first = (idx == 0);
                result_0 = 45'(10 * (idx + 1)); result_1 = 45'(idx); result_SIDM_carry = 4'h0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 5) begin
                checks++;
                if (in_ready !== ((cyc < 2) ? 1'b1 : 1'b0)) begin
                    fails++;
                    $display("FAIL bp_in_ready: cycle %0d in_ready=%0b required %0b", cyc, in_ready, (cyc < 2));
                end
            end
            if (cyc >= 2 && cyc < 5) begin
                front = (exp_acc.size() > 0) ? exp_acc[0] : 48'hX;
                checks++;
                if (out_valid !== 1'b1 || out_acc !== front) begin
                    fails++;
                    $display("FAIL bp_stable: cycle %0d valid=%0b acc=%h required 1/%h", cyc, out_valid, out_acc, front);
                end
            end
            acc_ev = in_valid && in_ready;
            drn_ev = out_valid && out_ready;
            if (drn_ev) begin
                checks++;
                if (exp_acc.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: acc=%h drained with nothing expected", out_acc);
                end else begin
                    front = exp_acc.pop_front();
                    void'(exp_mode.pop_front());
                    void'(exp_err.pop_front());
                    if (out_acc !== front) begin
                        fails++;
                        $display("FAIL bp_drain: beat %0d acc=%h required %h", got, out_acc, front);
                    end
                end
                $display("txn bp_drain %0d: acc=%h", got, out_acc);
                got++;
            end
            if (acc_ev) begin
                model_accept();
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 4) begin
            fails++;
            $display("FAIL bp_count: drained %0d required 4", got);
        end
    endtask

    task automatic test_mode_mismatch();
        do_reset();
        send_beat(2'b00, 1'b0, 1'b0, 1'b1, 45'd1000, 45'd1, 4'h0);
        send_beat(2'b00, 1'b0, 1'b0, 1'b0, 45'd10, 45'd5, 4'h0);
        @(posedge clk);
        #1;
        checks++;
        if (out_acc !== 48'd1016 || err_mode !== 1'b0) begin
            fails++;
            $display("FAIL mm_pre: acc=%0d err=%0b required 1016/0", out_acc, err_mode);
        end
        send_beat(2'b01, 1'b0, 1'b0, 1'b0, {18'd3, 27'h000_0A00}, {18'd4, 27'h0}, 4'h0);
        @(posedge clk);
        #1;
        checks++;
        if (out_acc !== {24'd7, 24'd5} || err_mode !== 1'b1 || out_mode !== 2'b01) begin
            fails++;
            $display("FAIL mm_load: acc=%h err=%0b mode=%0d required 000007000005/1/1", out_acc, err_mode, out_mode);
        end
        $display("txn mismatch: acc=%h err=%0b", out_acc, err_mode);
        send_beat(2'b11, 1'b0, 1'b0, 1'b1, 45'd2, 45'd3, 4'h0);
        @(posedge clk);
        #1;
        checks++;
        if (out_acc !== 48'd5 || err_mode !== 1'b1 || out_mode !== 2'b00) begin
            fails++;
            $display("FAIL mm_sticky: acc=%0d err=%0b mode=%0d required 5/1/0", out_acc, err_mode, out_mode);
        end
        $display("txn sticky: acc=%0d err=%0b", out_acc, err_mode);
    endtask

    task automatic test_async_reset();
        send_beat(2'b00, 1'b0, 1'b0, 1'b1, 45'd500, 45'd0, 4'h0);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 48'd0 || out_mode !== 2'b00 || err_mode !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rdy=%0b valid=%0b acc=%h mode=%0d err=%0b required 1/0/0/0/0",
                     in_ready, out_valid, out_acc, out_mode, err_mode);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_discard: out_valid=%0b required 0", out_valid);
        end
        model_reset();
        send_beat(2'b00, 1'b0, 1'b0, 1'b0, 45'd7, 45'd9, 4'h0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 48'd16 || err_mode !== 1'b0) begin
            fails++;
            $display("FAIL async_reload: valid=%0b acc=%0d err=%0b required 1/16/0", out_valid, out_acc, err_mode);
        end
        $display("txn after_reset: acc=%0d", out_acc);
    endtask

    task automatic test_random();
        int  sent;
        int  got;
        bit  acc_ev;
        bit  drn_ev;
        logic [47:0] e_acc;
        logic [1:0]  e_mode;
        bit          e_err;
        localparam int N = 200;
        do_reset();
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 5000 && got < N; cyc++) begin
            if (!in_valid && sent < N && $urandom_range(3) != 0) begin
                mode = 2'($urandom_range(3));
                if ($urandom_range(2) == 0) mode = 2'b01;
                a_sign = 1'($urandom);
                b_sign = 1'($urandom);
                first = ($urandom_range(3) == 0);
                result_0 = 45'({$urandom, $urandom});
                result_1 = 45'({$urandom, $urandom});
                result_SIDM_carry = 4'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            acc_ev = in_valid && in_ready;
            drn_ev = out_valid && out_ready;
            if (drn_ev) begin
                checks++;
                if (exp_acc.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: acc=%h drained with nothing expected", out_acc);
                end else begin
                    e_acc  = exp_acc.pop_front();
                    e_mode = exp_mode.pop_front();
                    e_err  = exp_err.pop_front();
                    if (out_acc !== e_acc || out_mode !== e_mode || err_mode !== e_err) begin
                        fails++;
                        $display("FAIL rnd_beat %0d: acc=%h mode=%0d err=%0b required %h/%0d/%0b",
                                 got, out_acc, out_mode, err_mode, e_acc, e_mode, e_err);
                    end
                end
                $display("txn rnd %0d: acc=%h mode=%0d err=%0b", got, out_acc, out_mode, err_mode);
                got++;
            end
            if (acc_ev) begin
                model_accept();
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc_ev) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != N) begin
            fails++;
            $display("FAIL rnd_count: drained %0d required %0d", got, N);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_add();
        test_lanes();
        test_backpressure();
        test_mode_mismatch();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pirdsp_partial_result_accumulator.md
# pirdsp_partial_result_accumulator

Consumer-side companion to the PIRDSP split-output multiplier. It takes the redundant partial-result pair (`result_0`, `result_1`, `result_SIDM_carry`) the multiplier emits each beat and performs the final carry-propagate add. In 27x18 mode it produces one 48-bit product; in sum-of-9x9 mode it produces two independent 20-bit dot-product lanes. It then accumulates successive beats in a 2-stage valid/ready pipeline and sits between the multiplier array and the DSP output/cascade logic.

## Interface
- `ACC_W`, 48: accumulator width in 27x18 mode; must be even and ≥ 46.
- `LANE_W`, `ACC_W/2`: per-lane accumulator width in sum-9x9 mode; must be ≥ 20.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low; clears all state.
- `in_valid`  in  1  a beat is presented.
- `in_ready`  out  1  the beat is accepted when `in_valid && in_ready`.
- `mode`  in  2  `2'b00` = 27x18; `2'b01` = sum-9x9; other codes are treated as `2'b00`.
- `a_sign`, `b_sign`  in  1 each  operand signedness for the beat.
- `first`  in  1  beat starts a new accumulation (load instead of add).
- `result_0`, `result_1`  in  45 each  signed partial results.
- `result_SIDM_carry`  in  4  lane carry bits; ignored in 27x18 mode.
- `out_valid`  out  1  output holds an accumulated value.
- `out_ready`  in  1  downstream accepts the output.
- `out_acc`  out  `ACC_W`  accumulator; in sum-9x9 mode `{lane1,lane0}`, each `LANE_W` bits.
- `out_mode`  out  2  mode of the value on `out_acc`.
- `err_mode`  out  1  sticky flag for a mode mismatch on a non-first beat.

## Operation
- **Stage 1, final add (registered on accept).**
  - 27x18: `sum = result_0 + result_1`, 45 bits. Zero-extend to `ACC_W` if `!a_sign && !b_sign`, otherwise sign-extend.
  - Sum-9x9, lane 0: `{c0,s0} = {carry[1:0],r0[26:0]} + {2'b00,r1[26:0]}`, giving 29 bits; `lane0 = bits[28:9]` (20 bits).
  - Sum-9x9, lane 1: `{carry[3:2],r0[44:27]} + {2'b00,r1[44:27]}`, truncated to 20 bits, is `lane1`.
  - Each lane is sign-extended to `LANE_W` if `a_sign || b_sign`, otherwise zero-extended.
  - No carry ever crosses between lanes.
- **Stage 2, accumulate (when S1 advances into S2).**
  - `acc_next = load ? sum : acc + sum`, modular, with no saturation.
  - In sum-9x9 mode each lane wraps independently at `LANE_W`.
  - `load = first || (mode != acc_mode)`.
  - A mismatch with `first=0` sets `err_mode`. It is cleared only by reset.
  - `acc_mode` is updated on every advance.
- `out_acc` is `acc` itself; each advance presents a new running value.

## Timing
- Reset: `in_ready=1`, `out_valid=0`, `out_acc=0`, `out_mode=2'b00`, `err_mode=0`, both stage valids 0, `acc_mode=2'b00`.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_acc` after edge N+1.
- Full throughput is one beat per cycle with `out_ready=1`.
- `advance = !out_valid || out_ready`; `in_ready = !s1_valid || advance` (combinational from `out_ready`).
- Simultaneous accept and drain in the same cycle is legal and loses no beat.
- With `out_ready=0`, `out_acc`/`out_mode` stay stable, at most two beats are held, and then `in_ready=0`.
- `in_valid` with `in_ready=0`: the inputs are ignored and the source must hold the beat.
- Reset asserted mid-accumulation: state clears immediately; the in-flight beats are discarded.

## Structure
- Shared package `pirdsp_pkg`:
  - mode constants `MODE_27X18=2'b00`, `MODE_SUM_9X9=2'b01`;
  - lane bit positions (27, 9, 18);
  - the width constant 20 for the 9x9 lane sum.
- One sub-module, `pirdsp_final_adder`: a combinational mode-aware final add plus extension that produces the `ACC_W`-bit `sum`. The pipeline and accumulator stay in the top module.

## Test plan
- **27x18 unsigned load then add.** `r0=100`, `r1=23`, `first=1`, then `r0=-5`, `r1=0`, `first=0`, signed → `out_acc` = 123, then 118, on consecutive cycles, with 2-cycle latency.
- **Sum-9x9 lane carry.** `r0[26:0]=27'h7FFFE00`, `r1[26:0]=27'h0000400`, carry=0, unsigned, `first=1` → lane0=`20'h40001`, with no effect on lane1.
- **Lane isolation.** lane1 inputs `r0[44:27]=18'h3FFFF`, `r1[44:27]=1`, `carry[3:2]=2'b11`, unsigned → lane1=`20'h00000` (wrap) and lane0 unchanged.
- **Backpressure.** Hold `out_ready=0` for 5 cycles while streaming 4 beats → only 2 are accepted, `in_ready=0` from the 3rd cycle, `out_acc` is stable, and all beats drain in order after release.
- **Mode mismatch.** After a 27x18 accumulation, send a sum-9x9 beat with `first=0` → that beat is loaded rather than added, `err_mode=1`, and the flag stays set.
- **Async reset.** Pulse `reset_n` low mid-stream between clock edges → all outputs return to their reset values immediately, and the next beat with `first=0` loads into a zero accumulator.
